control_logic: RTL and testbench
================================

// Module: control_logic
// PURPOSE
//   Main instruction decoder of the WISC-S15 single-issue datapath.
//   Maps the 4-bit instruction opcode to the control strobes for:
//     - RegFile read-port selects
//     - branch, call and return logic
//     - data-memory read/write
//     - ALU op/operand selects and sign-extend select
//   Decode is purely combinational (zero latency) so the decode stage meets timing within one cycle.
//   A single clocked element records a sticky illegal-opcode (ERR) flag.
// PARAMETERS
//   none (opcode width 4 and alu_op width 3 are fixed by the ISA)
// PORTS
//   clk           in   1  system clock; one clock domain, rising edge
//   rst_n         in   1  asynchronous, active-low reset
//   opcode        in   4  instruction opcode [15:12]
//   data_reg      out  1  RegFile read_data_1 sourced from Data Segment reg
//   call          out  1  RegFile read_data_1 sourced from Stack Pointer; CALL flow
//   rtrn          out  1  return (RET) flow control
//   branch        out  1  conditional-branch instruction
//   mem_to_reg    out  1  load: memory read data written back to RegFile
//   reg_to_mem    out  1  store: RegFile data written to memory
//   alu_op        out  3  ALU operation code
//   alu_src       out  1  1 = ALU operand B is immediate, 0 = register
//   sign_ext_sel  out  1  sign-extend select (1 = INC immediate format)
//   reg_rt_src    out  1  read_reg_2 selects rt field for SW store data
//   illegal_op    out  1  sticky flag: ERR opcode was decoded
// BEHAVIOUR
//   Opcode map:
//     0000 ADD,  0001 SUB,  0010 NAND, 0011 XOR
//     0100 INC,  0101 SRA,  0110 SRL,  0111 SLL
//     1000 LW,   1001 SW,   1010 LHB,  1011 LLB
//     1100 B,    1101 CALL, 1110 RET,  1111 ERR
//   Decode, combinational, valid for every opcode while rst_n=1:
//     alu_op       = opcode[2:0] for ALL 16 opcodes, including 1xxx
//     data_reg     = 1 iff LW or SW
//     mem_to_reg   = 1 iff LW
//     reg_to_mem   = 1 iff SW
//     reg_rt_src   = 1 iff SW
//     alu_src      = 1 iff LW, SW or INC
//     sign_ext_sel = 1 iff INC
//     branch       = 1 iff B
//     call         = 1 iff CALL
//     rtrn         = 1 iff RET
//     All other single-bit outputs are 0.
//   Opcode-specific rules:
//     - LHB, LLB and ERR assert no single-bit strobe.
//     - Shift opcodes (SRA/SRL/SLL) use alu_src=0.
//     - ALU arithmetic ops (ADD/SUB/NAND/XOR) use alu_src=0.
//   Non-0/1 opcode bits (X/Z): all single-bit strobes forced 0 via the default decode arm.
//   Reset:
//     - While rst_n=0, every decode output is forced to 0 (alu_op=000), asynchronously.
//     - illegal_op clears to 0 immediately on rst_n falling.
//   illegal_op:
//     - Set on the first rising clk edge with rst_n=1 and opcode=1111.
//     - Holds until the next reset.
//     - Has no effect on decode outputs.
//     - Reset released mid-ERR: the flag sets on the next rising edge, not at deassertion.
//   Outputs settle within the same cycle as an opcode change; no pipeline registers.
// TESTING
//   1. rst_n=0, any opcode -> all outputs 0, illegal_op=0; release -> decode follows opcode.
//   2. Sweep opcode 0..15 with rst_n=1, check each output:
//        - every step: alu_op==opcode[2:0]
//        - every strobe matches the table above
//   3. opcode=1000 (LW) -> data_reg=1, mem_to_reg=1, alu_src=1, alu_op=000; rest 0.
//   4. opcode=1001 (SW) -> data_reg=1, reg_to_mem=1, reg_rt_src=1, alu_src=1, alu_op=001.
//   5. opcode=0100 (INC) -> alu_src=1, sign_ext_sel=1, alu_op=100.
//      opcode=1100/1101/1110 -> only branch / call / rtrn respectively.
//   6. ERR sticky flag:
//        - opcode=1111 held over a clk edge -> illegal_op=1; stays 1 after opcode=0000.
//        - rst_n pulse low -> illegal_op=0 at once.

Source files
------------

// File: rtl/control_logic.sv
// -----------------------------------------------------------------------------
// control_logic -- main instruction decoder of the WISC-S15 datapath.
//
// Purpose:
//   Purely combinational decode of the 4-bit opcode into the control strobes
//   used by the register file, branch/call/return logic, data memory and ALU.
//   A single register holds a sticky flag recording that the ERR opcode was
//   decoded; it is cleared only by reset.
//
// Ports:
//   clk           in   1  system clock, rising edge
//   rst_n         in   1  asynchronous active-low reset
//   opcode        in   4  instruction opcode (instr[15:12])
//   data_reg      out  1  read_data_1 sourced from Data Segment reg (LW/SW)
//   call          out  1  read_data_1 sourced from Stack Pointer; CALL flow
//   rtrn          out  1  RET flow control
//   branch        out  1  conditional branch (B)
//   mem_to_reg    out  1  load write-back (LW)
//   reg_to_mem    out  1  store (SW)
//   alu_op        out  3  ALU operation, always opcode[2:0]
//   alu_src       out  1  1 = operand B immediate (LW/SW/INC)
//   sign_ext_sel  out  1  INC immediate format select
//   reg_rt_src    out  1  read_reg_2 selects rt for SW store data
//   illegal_op    out  1  sticky: ERR opcode decoded since last reset
// -----------------------------------------------------------------------------
module control_logic (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  output logic       data_reg,
  output logic       call,
  output logic       rtrn,
  output logic       branch,
  output logic       mem_to_reg,
  output logic       reg_to_mem,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       sign_ext_sel,
  output logic       reg_rt_src,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_NAND = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_INC  = 4'b0100,
    OP_SRA  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_LW   = 4'b1000,
    OP_SW   = 4'b1001,
    OP_LHB  = 4'b1010,
    OP_LLB  = 4'b1011,
    OP_B    = 4'b1100,
    OP_CALL = 4'b1101,
    OP_RET  = 4'b1110,
    OP_ERR  = 4'b1111
  } opcode_e;

  // Decode. Outputs are gated by rst_n so that reset forces every strobe and
  // alu_op to zero asynchronously. Opcodes with no strobes (arithmetic,
  // shifts, LHB, LLB, ERR) and non-0/1 opcode bits fall through to the
  // all-zero defaults.
  always_comb begin
    data_reg     = 1'b0;
    call         = 1'b0;
    rtrn         = 1'b0;
    branch       = 1'b0;
    mem_to_reg   = 1'b0;
    reg_to_mem   = 1'b0;
    alu_op       = '0;
    alu_src      = 1'b0;
    sign_ext_sel = 1'b0;
    reg_rt_src   = 1'b0;
    if (rst_n) begin
      alu_op = opcode[2:0];
      case (opcode)
        OP_INC: begin
          alu_src      = 1'b1;
          sign_ext_sel = 1'b1;
        end
        OP_LW: begin
          data_reg   = 1'b1;
          mem_to_reg = 1'b1;
          alu_src    = 1'b1;
        end
        OP_SW: begin
          data_reg   = 1'b1;
          reg_to_mem = 1'b1;
          reg_rt_src = 1'b1;
          alu_src    = 1'b1;
        end
        OP_B:    branch = 1'b1;
        OP_CALL: call   = 1'b1;
        OP_RET:  rtrn   = 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky illegal-opcode flag; sampled on the clock, so releasing reset
  // while ERR is present sets it on the following rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
    end else if (opcode == OP_ERR) begin
      illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_logic.sv
module tb_control_logic;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       data_reg, call, rtrn, branch, mem_to_reg, reg_to_mem;
  logic [2:0] alu_op;
  logic       alu_src, sign_ext_sel, reg_rt_src, illegal_op;

  control_logic dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .data_reg     (data_reg),
    .call         (call),
    .rtrn         (rtrn),
    .branch       (branch),
    .mem_to_reg   (mem_to_reg),
    .reg_to_mem   (reg_to_mem),
    .alu_op       (alu_op),
    .alu_src      (alu_src),
    .sign_ext_sel (sign_ext_sel),
    .reg_rt_src   (reg_rt_src),
    .illegal_op   (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic        exp_ill    = 1'b0;

  logic [12:0] sb_exp[$];
  string       sb_tag[$];

  // Packed order: data_reg call rtrn branch mem_to_reg reg_to_mem
  //               alu_op[2:0] alu_src sign_ext_sel reg_rt_src illegal_op
  function automatic logic [12:0] model(input logic [3:0] op, input logic rst,
                                        input logic ill);
    logic lw, sw, inc;
    if (!rst) return 13'b0;
    lw  = (op == 4'd8);
    sw  = (op == 4'd9);
    inc = (op == 4'd4);
    return {lw | sw, op == 4'd13, op == 4'd14, op == 4'd12, lw, sw,
            op[2:0], lw | sw | inc, inc, sw, ill};
  endfunction

  function automatic logic [12:0] observed();
    return {data_reg, call, rtrn, branch, mem_to_reg, reg_to_mem,
            alu_op, alu_src, sign_ext_sel, reg_rt_src, illegal_op};
  endfunction

  task automatic check();
    logic [12:0] e;
    logic [12:0] o;
    string       t;
    e = sb_exp.pop_front();
    t = sb_tag.pop_front();
    o = observed();
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", t, o, e);
    end
  endtask

  // Drive just after the falling edge, check 2 ns later (still before the
  // next rising edge). The rising edge that follows samples this opcode.
  task automatic step(input logic [3:0] op, input logic rst, input string tag);
    @(negedge clk);
    #1;
    opcode = op;
    rst_n  = rst;
    if (!rst) exp_ill = 1'b0;
    sb_exp.push_back(model(op, rst, exp_ill));
    sb_tag.push_back(tag);
    #2;
    check();
    if (rst && op == 4'hF) exp_ill = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 4'hF;

    // Reset holds everything at zero, even with ERR present over edges.
    step(4'hF, 1'b0, "reset_err");
    step(4'h9, 1'b0, "reset_sw");
    step(4'h7, 1'b0, "reset_sll");

    // Release and sweep every opcode except ERR.
    for (int unsigned i = 0; i < 15; i++)
      step(4'(i), 1'b1, $sformatf("sweep_%0d", i));

    // ERR: flag clear before the edge, set after, sticky afterwards.
    step(4'hF, 1'b1, "err_pre_edge");
    step(4'hF, 1'b1, "err_held");
    step(4'h0, 1'b1, "err_sticky_add");
    step(4'h8, 1'b1, "lw_with_flag");
    step(4'h9, 1'b1, "sw_with_flag");
    step(4'h4, 1'b1, "inc_with_flag");
    step(4'hC, 1'b1, "b_with_flag");
    step(4'hD, 1'b1, "call_with_flag");
    step(4'hE, 1'b1, "ret_with_flag");
    step(4'hA, 1'b1, "lhb_with_flag");

    // Asynchronous reset pulse mid-cycle clears the flag at once.
    step(4'h9, 1'b0, "async_reset");

    // Release with ERR present: flag must wait for the next rising edge.
    step(4'hF, 1'b1, "release_mid_err");
    step(4'h1, 1'b1, "flag_after_release");
    step(4'h6, 1'b1, "srl_flag_set");

    // Another reset clears, then normal decode without the flag.
    step(4'h3, 1'b0, "reset_again");
    step(4'hB, 1'b1, "llb_clean");
    step(4'h5, 1'b1, "sra_clean");
    step(4'h8, 1'b1, "lw_clean");

    if (sb_exp.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb_exp.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
